// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pkg
//  Description : Shared definitions for the SHA-256 compression core.
//                Holds the word width, the FIPS 180-4 round constants K,
//                the initial hash value H0..H7, the FSM state encoding and
//                a rotate-right helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

  localparam int WORD_W = 32;

  // Compression FSM: IDLE waits for start, ROUND runs 64 rounds,
  // FINAL folds the working variables back into the chaining value.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  localparam logic [WORD_W-1:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Initial hash value, H0 in the top word, matching the hash_in layout.
  localparam logic [8*WORD_W-1:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_if
//  Description : Block request / digest bus of the SHA-256 compression core.
//                master : requester (drives start, block_in, hash_in)
//                slave  : compression core (drives ready, done, hash_out)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sha256_if;
  import sha256_pkg::*;

  logic                 start;     // compress request, honoured when ready=1
  logic [16*WORD_W-1:0] block_in;  // W0 in bits 511:480 ... W15 in bits 31:0
  logic [8*WORD_W-1:0]  hash_in;   // H0 in bits 255:224 ... H7 in bits 31:0
  logic                 ready;     // idle and able to accept start
  logic                 done;      // one-cycle pulse on hash_out update
  logic [8*WORD_W-1:0]  hash_out;  // updated chaining value

  modport master (output start, block_in, hash_in,
                  input  ready, done, hash_out);
  modport slave  (input  start, block_in, hash_in,
                  output ready, done, hash_out);
endinterface
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_round
//  Description : Combinational SHA-256 round function. Working variables are
//                packed a (top word) .. h (bottom word).
//  Ports       : i_work - a..h before the round
//                i_k    - round constant K[t]
//                i_w    - schedule word W[t]
//                o_work - a..h after the round
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_round
  import sha256_pkg::*;
(
  input  logic [7:0][WORD_W-1:0] i_work,
  input  logic [WORD_W-1:0]      i_k,
  input  logic [WORD_W-1:0]      i_w,
  output logic [7:0][WORD_W-1:0] o_work
);

  logic [WORD_W-1:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [WORD_W-1:0] w_sig0, w_sig1, w_ch, w_maj, w_t1, w_t2;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_work;

  assign w_sig1 = rotr(w_e, 6) ^ rotr(w_e, 11) ^ rotr(w_e, 25);
  assign w_sig0 = rotr(w_a, 2) ^ rotr(w_a, 13) ^ rotr(w_a, 22);
  assign w_ch   = (w_e & w_f) ^ (~w_e & w_g);
  assign w_maj  = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
  assign w_t1   = w_h + w_sig1 + w_ch + i_k + i_w;
  assign w_t2   = w_sig0 + w_maj;

  assign o_work = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule
`default_nettype wire

// File: rtl/sha256_compress.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_compress
//  Description : Iterative SHA-256 compression, one round per clock.
//                Accepts a 512-bit block plus chaining value, produces the
//                updated chaining value 65 edges after acceptance.
//  Ports       : clk - rising-edge clock
//                rst - synchronous active-high reset
//                bus - sha256_if.slave (start/block_in/hash_in in,
//                      ready/done/hash_out out)
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_compress
  import sha256_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  sha256_if.slave  bus
);

  state_t                  r_state, w_state_nxt;
  logic [5:0]              r_t;
  // Schedule window: top word holds W[t], bottom word is the newest.
  logic [15:0][WORD_W-1:0] r_win;
  logic [7:0][WORD_W-1:0]  r_saved;
  logic [7:0][WORD_W-1:0]  r_work;
  logic [7:0][WORD_W-1:0]  r_hash;
  logic                    r_done;

  logic [7:0][WORD_W-1:0]  w_work_nxt;
  logic [WORD_W-1:0]       w_s0, w_s1, w_w_new;

  sha256_round u_round (
    .i_work (r_work),
    .i_k    (K[r_t]),
    .i_w    (r_win[15]),
    .o_work (w_work_nxt)
  );

  // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
  assign w_s0    = rotr(r_win[14], 7) ^ rotr(r_win[14], 18) ^ (r_win[14] >> 3);
  assign w_s1    = rotr(r_win[1], 17) ^ rotr(r_win[1], 19) ^ (r_win[1] >> 10);
  assign w_w_new = w_s1 + r_win[6] + w_s0 + r_win[15];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.start)     w_state_nxt = ST_ROUND;
      ST_ROUND: if (r_t == 6'd63)  w_state_nxt = ST_FINAL;
      ST_FINAL:                    w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
      r_win   <= '0;
      r_saved <= '0;
      r_work  <= '0;
      r_hash  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_win   <= bus.block_in;
            r_saved <= bus.hash_in;
            r_work  <= bus.hash_in;
            r_t     <= '0;
          end
        end
        ST_ROUND: begin
          r_work <= w_work_nxt;
          r_win  <= {r_win[14:0], w_w_new};
          r_t    <= r_t + 6'd1;  // wraps to 0 after 63; FSM has already left
        end
        ST_FINAL: begin
          for (int i = 0; i < 8; i++) r_hash[i] <= r_saved[i] + r_work[i];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready    = (r_state == ST_IDLE);
  assign bus.done     = r_done;
  assign bus.hash_out = r_hash;

endmodule
`default_nettype wire

// File: tb/tb_sha256_compress.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_compress
//  Description : Directed self-checking bench for sha256_compress using the
//                "abc" and empty-message single-block digests.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_compress;
  import sha256_pkg::*;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h00000000}}};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  sha256_if bus ();

  sha256_compress dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ticks until done is seen or the budget runs out; returns edges taken.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Issue one block, scramble the inputs afterwards, and check the result
  // on the done cycle. Leaves the bench sitting in the done cycle.
  task automatic run_block(input string tag, input logic [511:0] blk,
                           input logic [255:0] hin, input logic [255:0] dig);
    int n;
    bus.start    = 1'b1;
    bus.block_in = blk;
    bus.hash_in  = hin;
    tick();
    bus.start    = 1'b0;
    bus.block_in = {16{32'hdeadbeef}};
    bus.hash_in  = '0;
    chk({tag, "_ready_busy"}, {255'd0, bus.ready}, 256'd0);
    chk({tag, "_done_low"},   {255'd0, bus.done},  256'd0);
    wait_done(n);
    chk({tag, "_latency"}, 256'(n), 256'd65);
    chk({tag, "_digest"},  bus.hash_out, dig);
  endtask

  initial begin
    int n;
    logic seen;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.block_in = '0;
    bus.hash_in  = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ready", {255'd0, bus.ready}, 256'd1);
    chk("reset_done",  {255'd0, bus.done},  256'd0);
    chk("reset_hash",  bus.hash_out,        256'd0);

    // Reset must win over a simultaneous start.
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.block_in = BLK_ABC;
    bus.hash_in  = IV;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("rst_prio_ready", {255'd0, bus.ready}, 256'd1);

    // Single "abc" block, then the done pulse must be exactly one cycle.
    run_block("abc", BLK_ABC, IV, DIG_ABC);
    tick();
    chk("abc_done_pulse", {255'd0, bus.done}, 256'd0);
    chk("abc_ready_back", {255'd0, bus.ready}, 256'd1);
    chk("abc_hash_hold",  bus.hash_out, DIG_ABC);

    // Empty message.
    run_block("empty", BLK_EMPTY, IV, DIG_EMPTY);
    tick();
    chk("empty_done_pulse", {255'd0, bus.done}, 256'd0);

    // Start held high mid-block with another block must be ignored.
    bus.start    = 1'b1;
    bus.block_in = BLK_ABC;
    bus.hash_in  = IV;
    tick();
    bus.block_in = BLK_EMPTY;
    bus.hash_in  = 256'h1;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (n == 40) bus.start = 1'b0;
      tick();
      n++;
    end
    bus.start = 1'b0;
    chk("busy_latency", 256'(n), 256'd65);
    chk("busy_digest",  bus.hash_out, DIG_ABC);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("busy_no_extra_done", {255'd0, seen}, 256'd0);

    // Back-to-back: second start issued in the done cycle of the first.
    run_block("b2b_first",  BLK_ABC,   IV, DIG_ABC);
    run_block("b2b_second", BLK_EMPTY, IV, DIG_EMPTY);
    tick();

    // Reset around round 30 aborts the block.
    bus.start    = 1'b1;
    bus.block_in = BLK_ABC;
    bus.hash_in  = IV;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", {255'd0, bus.ready}, 256'd1);
    chk("midrst_done",  {255'd0, bus.done},  256'd0);
    chk("midrst_hash",  bus.hash_out,        256'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_done", {255'd0, seen}, 256'd0);
    run_block("after_rst", BLK_ABC, IV, DIG_ABC);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
